pose_anim_sequencer: RTL and testbench
======================================

Name: pose_anim_sequencer

Overview:
- Controls the pose-sprite ROM for the on-screen character.
- Takes pose requests from game logic, for example a "beat hit".
- Changes the displayed pose only at frame boundaries, so a pose switch never tears mid-frame.
- Holds each requested pose for a fixed number of frames, then returns to the standing pose (pose 0).
- Produces the scaled, pipelined ROM address for the current pixel; the existing ROM and palette stages follow it unchanged.

Parameters:
- NUM_POSES, 4: number of pose frames stored back-to-back in the ROM.
- FRAME_W, 128: sprite frame width in texels.
- FRAME_H, 260: sprite frame height in texels.
- HOLD_FRAMES, 6: number of video frames a requested pose is displayed.
- ADDR_W, 18: ROM address width; must satisfy NUM_POSES*FRAME_W*FRAME_H <= 2^ADDR_W.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column, 0..799, including blanking.
- DrawY  in  10  current pixel row, 0..524, including blanking.
- req_valid  in  1  single-cycle pose request strobe.
- req_pose  in  $clog2(NUM_POSES)  requested pose index.
- busy  out  1  high while a non-standing pose is pending or being shown.
- pose_idx  out  $clog2(NUM_POSES)  pose currently being displayed.
- frame_tick  out  1  one-cycle pulse marking the frame boundary.
- rom_address  out  ADDR_W  sprite ROM address for the pixel presented two cycles earlier.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pose_idx=0, pending cleared, hold_cnt=0, busy=0, frame_tick=0, rom_address=0, both pipeline stages zeroed.
- frame_tick: registered; high for exactly one cycle after the sample where DrawX==799 && DrawY==524.
- All pose_idx updates happen on the cycle frame_tick is high.
- FSM states:
  - IDLE: pose_idx=0. On req_valid: latch req_pose into pending, go to ARMED.
  - ARMED: waiting for frame_tick. On frame_tick: pose_idx<=pending, hold_cnt<=HOLD_FRAMES-1, go to SHOW.
  - SHOW: each frame_tick decrements hold_cnt. When frame_tick arrives with hold_cnt==0: pose_idx<=0, go to IDLE.
- req_valid in ARMED: pending overwritten; last request wins.
- req_valid in SHOW: pending latched, go to ARMED. The current pose stays until the next frame_tick, then the new pose starts with a fresh hold count.
- req_valid and frame_tick in the same cycle:
  - The tick is processed first using the old pending value.
  - The new request is then latched, and the state becomes ARMED.
  - Exception: from IDLE, the request is latched and applied on the next tick, not the current one.
- req_pose==0 is legal; it behaves as a normal request with standing-pose artwork.
- req_pose >= NUM_POSES: request ignored.
- busy = (state != IDLE).
- Address pipeline:
  - Stage 1 registers sx = (DrawX*FRAME_W)/640 and sy = (DrawY*FRAME_H)/480, computed with full-width intermediates (≥20 bits).
  - Stage 2 registers rom_address = pose_idx*FRAME_W*FRAME_H + sy*FRAME_W + sx.
  - Latency: 2 cycles from DrawX/DrawY to rom_address.
  - Outside the visible region (DrawX>=640 or DrawY>=480), rom_address is forced to 0.
- Reset mid-animation: immediate return to IDLE with pose 0; any pending request is lost.

Optional Feature:
- Macro: POSE_FLIP_EN.
- When defined:
  - Adds input port flip_req (1 bit), sampled on frame_tick.
  - While the latched flip is 1, stage 1 uses sx' = FRAME_W-1-sx (horizontal mirror).
  - The latched flip resets to 0.
- When undefined: no port and no mirroring logic; addresses are unmirrored.

Decomposition:
- Package pose_anim_pkg holds:
  - the state enum (IDLE, ARMED, SHOW);
  - the screen constants H_VISIBLE=640, V_VISIBLE=480, H_TOTAL=800, V_TOTAL=525;
  - the frame-size helper constant FRAME_TEXELS=FRAME_W*FRAME_H.
- One sub-module, sprite_addr_scaler, contains the 2-stage address pipeline (inputs: DrawX, DrawY, pose_idx, flip). The FSM stays in the top module.

Test Plan:
- Reset release, then free-running counters → pose_idx=0, busy=0; frame_tick pulses once per 420000 cycles; at DrawX=320, DrawY=240 the output two cycles later is rom_address=64+130*128=16704.
- req_valid with req_pose=2 mid-frame → busy=1 immediately; pose_idx stays 0 until the next frame_tick, then becomes 2; it returns to 0 on the 6th tick after that; rom_address at (0,0) is 66560 while pose 2 is shown.
- req_pose=1 then req_pose=3 in the same frame (ARMED) → pose 3 is shown at the next tick; pose 1 is never displayed.
- req_pose=3 issued during SHOW of pose 2 at hold_cnt=2 → pose 2 is held until the next tick, then pose 3 for 6 frames.
- Reset asserted during SHOW → pose_idx=0, busy=0 and rom_address=0 asynchronously; no pose change on the following tick.
- With POSE_FLIP_EN defined: flip_req=1 at a tick, DrawX=0, DrawY=0, pose 0 → rom_address=127.

Source files
------------

// File: rtl/pose_anim_pkg.sv
// Shared types and screen/frame constants for the pose animation sequencer.
// Combinational constants only; no latency, no flow control.
package pose_anim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  localparam int FRAME_W_DEF = 128;
  localparam int FRAME_H_DEF = 260;

  function automatic int frame_texels(input int w, input int h);
    return w * h;
  endfunction

  localparam int FRAME_TEXELS = frame_texels(FRAME_W_DEF, FRAME_H_DEF);

endpackage

// File: rtl/pose_anim_sequencer_scaler.sv
// Two-stage sprite ROM address pipeline: scale screen coords to texels, then add pose base.
// Latency 2 cycles, free-running, no backpressure; off-screen pixels map to address 0.
module sprite_addr_scaler
  import pose_anim_pkg::*;
#(
  parameter int NUM_POSES = 4,
  parameter int FRAME_W   = FRAME_W_DEF,
  parameter int FRAME_H   = FRAME_H_DEF,
  parameter int TEXELS    = FRAME_TEXELS,
  parameter int ADDR_W    = 18,
  localparam int PW       = $clog2(NUM_POSES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_draw_x,
  input  logic [9:0]        i_draw_y,
  input  logic [PW-1:0]     i_pose_idx,
`ifdef POSE_FLIP_EN
  input  logic              i_flip,
`endif
  output logic [ADDR_W-1:0] o_rom_address
);

  localparam int SXW = $clog2(FRAME_W);
  localparam int SYW = $clog2(FRAME_H);

  logic [19:0]       w_x_prod, w_y_prod;
  logic [SXW-1:0]    w_sx, w_sx_m;
  logic [SYW-1:0]    w_sy;
  logic              w_vis;
  logic [ADDR_W-1:0] w_addr;

  logic [SXW-1:0]    r_sx;
  logic [SYW-1:0]    r_sy;
  logic              r_vis;
  logic [ADDR_W-1:0] r_addr;

  // 20-bit products: 799*128 and 524*260 both exceed 16 bits
  assign w_x_prod = 20'(i_draw_x) * 20'(FRAME_W);
  assign w_y_prod = 20'(i_draw_y) * 20'(FRAME_H);
  assign w_sx     = SXW'(w_x_prod / 20'(H_VISIBLE));
  assign w_sy     = SYW'(w_y_prod / 20'(V_VISIBLE));
  assign w_vis    = (i_draw_x < 10'(H_VISIBLE)) && (i_draw_y < 10'(V_VISIBLE));

`ifdef POSE_FLIP_EN
  assign w_sx_m = i_flip ? (SXW'(FRAME_W - 1) - w_sx) : w_sx;
`else
  assign w_sx_m = w_sx;
`endif

  assign w_addr = ADDR_W'(i_pose_idx) * ADDR_W'(TEXELS)
                + ADDR_W'(r_sy) * ADDR_W'(FRAME_W)
                + ADDR_W'(r_sx);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_vis  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_sx   <= w_sx_m;
      r_sy   <= w_sy;
      r_vis  <= w_vis;
      r_addr <= r_vis ? w_addr : '0;
    end
  end

  assign o_rom_address = r_addr;

endmodule

// File: rtl/pose_anim_sequencer.sv
// Pose request sequencer: switches sprite pose only on frame ticks, holds HOLD_FRAMES, returns to pose 0.
// Address latency 2 cycles; requests never stall (last wins). Optional mirroring via POSE_FLIP_EN.
module pose_anim_sequencer
  import pose_anim_pkg::*;
#(
  parameter int NUM_POSES   = 4,
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int FRAME_H     = FRAME_H_DEF,
  parameter int HOLD_FRAMES = 6,
  parameter int ADDR_W      = 18,
  localparam int PW         = $clog2(NUM_POSES)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              req_valid,
  input  logic [PW-1:0]     req_pose,
`ifdef POSE_FLIP_EN
  input  logic              flip_req,
`endif
  output logic              busy,
  output logic [PW-1:0]     pose_idx,
  output logic              frame_tick,
  output logic [ADDR_W-1:0] rom_address
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_t        r_state;
  logic [PW-1:0] r_pose;
  logic [PW-1:0] r_pending;
  logic [HW-1:0] r_hold;
  logic          r_frame_tick;
  logic          r_flip;
  logic          w_req_ok;
  logic          w_eof;

  assign w_req_ok = req_valid && (int'(req_pose) < NUM_POSES);
  assign w_eof    = (DrawX == 10'(H_TOTAL - 1)) && (DrawY == 10'(V_TOTAL - 1));

  // A request arriving with a tick is latched after the tick has consumed the old pending pose
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pose       <= '0;
      r_pending    <= '0;
      r_hold       <= '0;
      r_frame_tick <= 1'b0;
      r_flip       <= 1'b0;
    end else begin
      r_frame_tick <= w_eof;
`ifdef POSE_FLIP_EN
      if (r_frame_tick) r_flip <= flip_req;
`else
      r_flip <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_pose <= '0;
          if (w_req_ok) begin
            r_pending <= req_pose;
            r_state   <= ARMED;
          end
        end
        ARMED: begin
          if (r_frame_tick) begin
            r_pose  <= r_pending;
            r_hold  <= HW'(HOLD_FRAMES - 1);
            r_state <= SHOW;
          end
          if (w_req_ok) begin
            r_pending <= req_pose;
            r_state   <= ARMED;
          end
        end
        SHOW: begin
          if (r_frame_tick) begin
            if (r_hold == '0) begin
              r_pose  <= '0;
              r_state <= IDLE;
            end else begin
              r_hold <= r_hold - HW'(1);
            end
          end
          if (w_req_ok) begin
            r_pending <= req_pose;
            r_state   <= ARMED;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign pose_idx   = r_pose;
  assign frame_tick = r_frame_tick;

  sprite_addr_scaler #(
    .NUM_POSES (NUM_POSES),
    .FRAME_W   (FRAME_W),
    .FRAME_H   (FRAME_H),
    .TEXELS    (frame_texels(FRAME_W, FRAME_H)),
    .ADDR_W    (ADDR_W)
  ) u_scaler (
    .i_clk         (vga_clk),
    .i_rst         (reset),
    .i_draw_x      (DrawX),
    .i_draw_y      (DrawY),
    .i_pose_idx    (r_pose),
`ifdef POSE_FLIP_EN
    .i_flip        (r_flip),
`endif
    .o_rom_address (rom_address)
  );

`ifndef POSE_FLIP_EN
  logic w_unused_flip;
  assign w_unused_flip = r_flip;
`endif

endmodule

// File: tb/tb_pose_anim_sequencer.sv
// Randomized self-checking bench for pose_anim_sequencer against a frame-level pose/hold model.
module tb_pose_anim_sequencer;

  localparam int NP = 4;
  localparam int FW = 128;
  localparam int FH = 260;
  localparam int HOLD = 6;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_pose = '0;
  logic        busy;
  logic [1:0]  pose_idx;
  logic        frame_tick;
  logic [17:0] rom_address;

  pose_anim_sequencer dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .req_valid(req_valid), .req_pose(req_pose), .busy(busy),
    .pose_idx(pose_idx), .frame_tick(frame_tick), .rom_address(rom_address)
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_pass = 0;

  // Model: displayed pose, frames of display remaining, one pending request slot
  int m_pose, m_rem, m_pend, m_s1x, m_s1y, m_addr;
  bit m_pend_v, m_last_eof;

  function automatic int exp_addr(input int x, input int y, input int p);
    if (x >= 640 || y >= 480) return 0;
    return p * FW * FH + ((y * FH) / 480) * FW + (x * FW) / 640;
  endfunction

  function automatic bit m_busy();
    return m_pend_v || (m_rem > 0);
  endfunction

  task automatic model_reset();
    m_pose = 0; m_rem = 0; m_pend = 0; m_pend_v = 0;
    m_last_eof = 0; m_s1x = 700; m_s1y = 0; m_addr = 0;
  endtask

  task automatic step(input int x, input int y, input bit rv, input int rp);
    bit tick;
    DrawX = 10'(x); DrawY = 10'(y); req_valid = rv; req_pose = 2'(rp);
    @(posedge vga_clk);
    tick = m_last_eof;
    m_addr = exp_addr(m_s1x, m_s1y, m_pose);
    m_s1x = x; m_s1y = y;
    if (tick) begin
      if (m_pend_v) begin
        m_pose = m_pend; m_rem = HOLD; m_pend_v = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_pose = 0;
      end
    end
    if (rv && rp < NP) begin
      m_pend_v = 1; m_pend = rp;
    end
    m_last_eof = (x == 799 && y == 524);
    @(negedge vga_clk);
  endtask

  // Visible pixels, then the end-of-frame pixel, then the cycle on which the tick acts
  task automatic frame(input int n, input int req_at, input int rp);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 639), $urandom_range(0, 479), k == req_at, rp);
    step(799, 524, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    n_checks++; if (pose_idx !== 2'd0) $display("FAIL reset_pose got=%0d exp=0", pose_idx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if (frame_tick !== 1'b0) $display("FAIL reset_tick got=%0b exp=0", frame_tick); else n_pass++;
    n_checks++; if (rom_address !== 18'd0) $display("FAIL reset_addr got=%0d exp=0", rom_address); else n_pass++;
  endtask

  task automatic test_idle_addr();
    int ticks = 0;
    step(320, 240, 0, 0);
    step(0, 0, 0, 0);
    n_checks++; if (rom_address !== 18'd16704) $display("FAIL center_addr got=%0d exp=16704", rom_address); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 798), $urandom_range(0, 523), 0, 0);
      if (frame_tick) ticks++;
    end
    n_checks++; if (ticks != 0) $display("FAIL tick_spurious got=%0d exp=0", ticks); else n_pass++;
    step(799, 524, 0, 0);
    n_checks++; if (frame_tick !== 1'b1) $display("FAIL tick_pulse got=%0b exp=1", frame_tick); else n_pass++;
    step(0, 0, 0, 0);
    n_checks++; if (frame_tick !== 1'b0) $display("FAIL tick_width got=%0b exp=0", frame_tick); else n_pass++;
    n_checks++; if (pose_idx !== 2'd0 || busy !== 1'b0) $display("FAIL idle_tick pose=%0d busy=%0b exp=0/0", pose_idx, busy); else n_pass++;
  endtask

  task automatic test_single_pose();
    step(100, 100, 1, 2);
    n_checks++; if (busy !== 1'b1 || pose_idx !== 2'd0) $display("FAIL req_armed busy=%0b pose=%0d exp=1/0", busy, pose_idx); else n_pass++;
    frame(5, -1, 0);
    n_checks++; if (pose_idx !== 2'd2) $display("FAIL pose2_start got=%0d exp=2", pose_idx); else n_pass++;
    step(5, 5, 0, 0);
    n_checks++; if (rom_address !== 18'd66560) $display("FAIL pose2_addr got=%0d exp=66560", rom_address); else n_pass++;
    for (int i = 1; i <= HOLD; i++) begin
      frame(4, -1, 0);
      n_checks++;
      if (pose_idx !== 2'(m_pose) || busy !== m_busy())
        $display("FAIL hold_frame%0d pose=%0d busy=%0b exp=%0d/%0b", i, pose_idx, busy, m_pose, m_busy());
      else n_pass++;
    end
    n_checks++; if (pose_idx !== 2'd0 || busy !== 1'b0) $display("FAIL hold_end pose=%0d busy=%0b exp=0/0", pose_idx, busy); else n_pass++;
  endtask

  task automatic test_last_wins();
    bit saw1 = 0;
    step(200, 50, 1, 1);
    step(300, 60, 1, 3);
    frame(3, -1, 0);
    n_checks++; if (pose_idx !== 2'd3) $display("FAIL last_wins got=%0d exp=3", pose_idx); else n_pass++;
    for (int i = 0; i < HOLD; i++) begin
      frame(3, -1, 0);
      if (pose_idx == 2'd1) saw1 = 1;
    end
    n_checks++; if (saw1 || pose_idx !== 2'd0) $display("FAIL last_wins_end saw1=%0b pose=%0d exp=0/0", saw1, pose_idx); else n_pass++;
  endtask

  task automatic test_preempt();
    step(10, 10, 1, 2);
    frame(3, -1, 0);
    for (int i = 0; i < 3; i++) frame(3, -1, 0);
    step(50, 50, 1, 3);
    n_checks++; if (pose_idx !== 2'd2 || busy !== 1'b1) $display("FAIL preempt_hold pose=%0d busy=%0b exp=2/1", pose_idx, busy); else n_pass++;
    frame(4, -1, 0);
    n_checks++; if (pose_idx !== 2'd3) $display("FAIL preempt_switch got=%0d exp=3", pose_idx); else n_pass++;
    for (int i = 1; i <= HOLD; i++) begin
      frame(3, -1, 0);
      n_checks++;
      if (pose_idx !== 2'((i < HOLD) ? 3 : 0))
        $display("FAIL preempt_frame%0d got=%0d exp=%0d", i, pose_idx, (i < HOLD) ? 3 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_same_cycle();
    step(799, 524, 0, 0);
    step(0, 0, 1, 1);
    n_checks++; if (pose_idx !== 2'd0 || busy !== 1'b1) $display("FAIL idle_tick_req pose=%0d busy=%0b exp=0/1", pose_idx, busy); else n_pass++;
    frame(3, -1, 0);
    n_checks++; if (pose_idx !== 2'd1) $display("FAIL idle_tick_apply got=%0d exp=1", pose_idx); else n_pass++;
    step(10, 10, 1, 2);
    step(799, 524, 0, 0);
    step(0, 0, 1, 3);
    n_checks++; if (pose_idx !== 2'd2 || busy !== 1'b1) $display("FAIL armed_tick_req pose=%0d busy=%0b exp=2/1", pose_idx, busy); else n_pass++;
    frame(3, -1, 0);
    n_checks++; if (pose_idx !== 2'd3) $display("FAIL armed_tick_next got=%0d exp=3", pose_idx); else n_pass++;
    for (int i = 0; i < HOLD; i++) frame(2, -1, 0);
    n_checks++; if (pose_idx !== 2'd0 || busy !== 1'b0) $display("FAIL same_cycle_end pose=%0d busy=%0b exp=0/0", pose_idx, busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(20, 20, 1, 1);
    frame(3, -1, 0);
    step(0, 0, 0, 0);
    n_checks++; if (rom_address !== 18'd33280 || pose_idx !== 2'd1) $display("FAIL pre_reset addr=%0d pose=%0d exp=33280/1", rom_address, pose_idx); else n_pass++;
    step(30, 30, 1, 2);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (pose_idx !== 2'd0 || busy !== 1'b0 || rom_address !== 18'd0)
      $display("FAIL async_reset pose=%0d busy=%0b addr=%0d exp=0/0/0", pose_idx, busy, rom_address); else n_pass++;
    @(negedge vga_clk);
    reset = 1'b0;
    model_reset();
    step(799, 524, 0, 0);
    step(0, 0, 0, 0);
    n_checks++; if (pose_idx !== 2'd0 || busy !== 1'b0) $display("FAIL post_reset_tick pose=%0d busy=%0b exp=0/0", pose_idx, busy); else n_pass++;
  endtask

  task automatic test_random();
    int n, x, y, rp;
    bit rv;
    for (int f = 0; f < 150; f++) begin
      n = $urandom_range(3, 10);
      for (int k = 0; k < n + 2; k++) begin
        if (k == n) begin x = 799; y = 524; end
        else begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
        rv = ($urandom_range(0, 5) == 0);
        rp = $urandom_range(0, NP - 1);
        step(x, y, rv, rp);
        n_checks++;
        if (pose_idx !== 2'(m_pose)) $display("FAIL rnd_pose f=%0d got=%0d exp=%0d", f, pose_idx, m_pose); else n_pass++;
        n_checks++;
        if (busy !== m_busy()) $display("FAIL rnd_busy f=%0d got=%0b exp=%0b", f, busy, m_busy()); else n_pass++;
        n_checks++;
        if (frame_tick !== m_last_eof) $display("FAIL rnd_tick f=%0d got=%0b exp=%0b", f, frame_tick, m_last_eof); else n_pass++;
        n_checks++;
        if (rom_address !== 18'(m_addr)) $display("FAIL rnd_addr f=%0d got=%0d exp=%0d", f, rom_address, m_addr); else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge vga_clk);
    reset = 1'b0;
    test_reset();
    test_idle_addr();
    test_single_pose();
    test_last_wins();
    test_preempt();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
